lb_uart_rx_host_ctrl: RTL and testbench

Host-side controller and configurator for the UART receiver. It exposes the receiver's format, baud prescale and enable as PicoBlaze I/O-port registers, and drives those settings onto the receive control unit/datapath. It captures each completed frame on the receiver's done pulse and checks parity and stop bit. Results go into a small receive FIFO that the processor drains, with an interrupt request.

---
 rtl/lb_uart_rx_host_ctrl_if.sv | 18 +
 rtl/lb_uart_rx_host_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lb_uart_rx_host_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lb_uart_rx_host_ctrl_if.sv
// PicoBlaze I/O-port bus between the processor and the UART receive host controller.
interface lb_uart_rx_host_ctrl_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;

    modport master (
        output port_id, write_strobe, read_strobe, out_port,
        input  in_port
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port,
        output in_port
    );
endinterface

// File: rtl/lb_uart_rx_host_ctrl.sv
// UART receiver host controller: config registers, frame capture with parity/stop
// checking, and a small receive FIFO drained over the PicoBlaze I/O ports.
module lb_uart_rx_host_ctrl #(
    parameter logic [7:0]  BASE_ADDR    = 8'h10,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [19:0] PRESCALE_RST = 20'd325
) (
    input  logic                        clk,
    input  logic                        reset,
    lb_uart_rx_host_ctrl_if.slave       bus,
    input  logic                        rx_done,
    input  logic [10:0]                 rx_frame,
    output logic                        cs,
    output logic                        bit8,
    output logic                        parity_en,
    output logic [19:0]                 baud_prescale,
    output logic                        irq
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [7:0] ADDR_CTRL   = BASE_ADDR + 8'd0;
    localparam logic [7:0] ADDR_PRE0   = BASE_ADDR + 8'd1;
    localparam logic [7:0] ADDR_PRE1   = BASE_ADDR + 8'd2;
    localparam logic [7:0] ADDR_PRE2   = BASE_ADDR + 8'd3;
    localparam logic [7:0] ADDR_STATUS = BASE_ADDR + 8'd4;
    localparam logic [7:0] ADDR_DATA   = BASE_ADDR + 8'd5;

    // Parity over the (already bit8-masked) data field, inverted for odd parity.
    function automatic logic frame_parity(input logic [8:0] data, input logic odd);
        frame_parity = (^data) ^ odd;
    endfunction

    logic             en_r, bit8_r, par_en_r, odd_r, irq_en_r;
    logic [19:0]      prescale_r;
    logic [10:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic             ovr_r, ovr_nxt_s, irq_r, irq_nxt_s, irq_en_nxt_s;
    logic [7:0]       in_port_r, rdata_s;
    logic             wr_ctrl_s, wr_pre0_s, wr_pre1_s, wr_pre2_s, wr_status_s;
    logic             empty_s, full_s, pop_s, push_req_s, push_s, drop_s;
    logic [8:0]       data9_s;
    logic [10:0]      entry_s, head_s;

    // Bus decode, FIFO next-state and interrupt next-state.
    always_comb begin
        wr_ctrl_s   = bus.write_strobe && (bus.port_id == ADDR_CTRL);
        wr_pre0_s   = bus.write_strobe && (bus.port_id == ADDR_PRE0);
        wr_pre1_s   = bus.write_strobe && (bus.port_id == ADDR_PRE1);
        wr_pre2_s   = bus.write_strobe && (bus.port_id == ADDR_PRE2);
        wr_status_s = bus.write_strobe && (bus.port_id == ADDR_STATUS);

        empty_s    = (count_r == CNT_ZERO);
        full_s     = (count_r == CNT_FULL);
        pop_s      = bus.read_strobe && (bus.port_id == ADDR_DATA) && !empty_s;
        push_req_s = rx_done && en_r;
        // A pop in the same cycle makes room, so a full FIFO still accepts the frame.
        push_s     = push_req_s && (!full_s || pop_s);
        drop_s     = push_req_s && full_s && !pop_s;

        data9_s = {bit8_r & rx_frame[8], rx_frame[7:0]};
        entry_s = {~rx_frame[10],
                   par_en_r & (frame_parity(data9_s, odd_r) != rx_frame[9]),
                   data9_s};

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        if (drop_s) begin
            ovr_nxt_s = 1'b1;
        end else if (wr_status_s && bus.out_port[2]) begin
            ovr_nxt_s = 1'b0;
        end else begin
            ovr_nxt_s = ovr_r;
        end

        if (wr_ctrl_s) begin
            irq_en_nxt_s = bus.out_port[4];
        end else begin
            irq_en_nxt_s = irq_en_r;
        end
        irq_nxt_s = irq_en_nxt_s && ((count_nxt_s != CNT_ZERO) || ovr_nxt_s);
    end

    // Read mux; head fields read as zero while the FIFO is empty.
    always_comb begin
        if (empty_s) begin
            head_s = 11'h000;
        end else begin
            head_s = fifo_mem_r[rd_ptr_r];
        end
        case (bus.port_id)
            ADDR_CTRL:   rdata_s = {3'b000, irq_en_r, odd_r, par_en_r, bit8_r, en_r};
            ADDR_PRE0:   rdata_s = prescale_r[7:0];
            ADDR_PRE1:   rdata_s = prescale_r[15:8];
            ADDR_PRE2:   rdata_s = {4'b0000, prescale_r[19:16]};
            ADDR_STATUS: rdata_s = {2'b00, head_s[8], head_s[10], head_s[9], ovr_r, full_s, empty_s};
            ADDR_DATA:   rdata_s = head_s[7:0];
            default:     rdata_s = 8'h00;
        endcase
    end

    // Configuration registers; format and prescale are locked while enabled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            en_r       <= 1'b0;
            bit8_r     <= 1'b0;
            par_en_r   <= 1'b0;
            odd_r      <= 1'b0;
            irq_en_r   <= 1'b0;
            prescale_r <= PRESCALE_RST;
        end else begin
            if (wr_ctrl_s) begin
                en_r     <= bus.out_port[0];
                irq_en_r <= bus.out_port[4];
                if (!en_r) begin
                    bit8_r   <= bus.out_port[1];
                    par_en_r <= bus.out_port[2];
                    odd_r    <= bus.out_port[3];
                end
            end
            if (!en_r) begin
                if (wr_pre0_s) prescale_r[7:0]   <= bus.out_port;
                if (wr_pre1_s) prescale_r[15:8]  <= bus.out_port;
                if (wr_pre2_s) prescale_r[19:16] <= bus.out_port[3:0];
            end
        end
    end

    // FIFO pointers, count, sticky overrun, irq and registered read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= CNT_ZERO;
            ovr_r     <= 1'b0;
            irq_r     <= 1'b0;
            in_port_r <= 8'h00;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r   <= count_nxt_s;
            ovr_r     <= ovr_nxt_s;
            irq_r     <= irq_nxt_s;
            in_port_r <= rdata_s;
        end
    end

    // FIFO storage; contents are don't-care until counted in.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= entry_s;
        end
    end

    assign bus.in_port    = in_port_r;
    assign cs             = en_r;
    assign bit8           = bit8_r;
    assign parity_en      = par_en_r;
    assign baud_prescale  = prescale_r;
    assign irq            = irq_r;
endmodule

// File: tb/tb_lb_uart_rx_host_ctrl.sv
// Randomized bench for lb_uart_rx_host_ctrl against a queue-based register/FIFO model.
module tb_lb_uart_rx_host_ctrl;
    localparam logic [7:0] BASE  = 8'h10;
    localparam int         DEPTH = 4;
    localparam logic [7:0] A_CTRL = BASE, A_P0 = BASE + 8'd1, A_P1 = BASE + 8'd2,
                           A_P2 = BASE + 8'd3, A_ST = BASE + 8'd4, A_DATA = BASE + 8'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_done = 1'b0;
    logic [10:0] rx_frame = 11'h000;
    logic        cs, bit8, parity_en, irq;
    logic [19:0] baud_prescale;

    lb_uart_rx_host_ctrl_if bus_if();

    lb_uart_rx_host_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .PRESCALE_RST(20'd325)) dut (
        .clk(clk), .reset(reset), .bus(bus_if),
        .rx_done(rx_done), .rx_frame(rx_frame),
        .cs(cs), .bit8(bit8), .parity_en(parity_en),
        .baud_prescale(baud_prescale), .irq(irq)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] last_rd;

    // Model state
    bit          m_en, m_b8, m_pe, m_odd, m_irqen, m_ovr;
    logic [19:0] m_pre;
    logic [10:0] m_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_b8 = 0; m_pe = 0; m_odd = 0; m_irqen = 0; m_ovr = 0;
        m_pre = 20'd325;
        m_q.delete();
    endtask

    function automatic logic [7:0] model_rdata(input logic [7:0] addr);
        logic [10:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 11'h000;
        if (addr == A_CTRL) return {3'b000, m_irqen, m_odd, m_pe, m_b8, m_en};
        if (addr == A_P0)   return m_pre[7:0];
        if (addr == A_P1)   return m_pre[15:8];
        if (addr == A_P2)   return {4'b0000, m_pre[19:16]};
        if (addr == A_ST)   return {2'b00, h[8], h[10], h[9], m_ovr,
                                    m_q.size() == DEPTH, m_q.size() == 0};
        if (addr == A_DATA) return h[7:0];
        return 8'h00;
    endfunction

    function automatic logic [10:0] model_entry(input logic [10:0] f);
        logic [8:0] d;
        int ones;
        bit par, perr;
        d = f[8:0];
        if (!m_b8) d[8] = 1'b0;
        ones = $countones(d);
        par  = ((ones % 2) == 1) ^ m_odd;
        perr = m_pe && (par != f[9]);
        return {~f[10], perr, d};
    endfunction

    // One bus cycle: optional read, optional write, optional rx_done pulse.
    task automatic step(input bit rd, input bit wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input bit rx, input logic [10:0] frame);
        logic [7:0]  exp;
        logic [10:0] ent;
        bit          push, pop;
        @(negedge clk);
        bus_if.port_id = addr; bus_if.read_strobe = rd; bus_if.write_strobe = wr;
        bus_if.out_port = wdata; rx_done = rx; rx_frame = frame;
        exp  = model_rdata(addr);
        pop  = rd && (addr == A_DATA) && (m_q.size() > 0);
        push = 0;
        if (rx && m_en) begin
            ent = model_entry(frame);
            if (m_q.size() == DEPTH && !pop) m_ovr = 1;
            else push = 1;
        end
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(ent);
        if (wr) begin
            if (addr == A_CTRL) begin
                if (!m_en) begin m_b8 = wdata[1]; m_pe = wdata[2]; m_odd = wdata[3]; end
                m_en = wdata[0]; m_irqen = wdata[4];
            end else if (addr == A_P0 && !m_en) m_pre[7:0]   = wdata;
            else if (addr == A_P1 && !m_en)     m_pre[15:8]  = wdata;
            else if (addr == A_P2 && !m_en)     m_pre[19:16] = wdata[3:0];
            else if (addr == A_ST && wdata[2])  m_ovr = 0;
        end
        @(posedge clk); #1;
        last_rd = bus_if.in_port;
        if (rd) check("read_data", {24'h0, last_rd}, {24'h0, exp});
        bus_if.read_strobe = 0; bus_if.write_strobe = 0; rx_done = 0;
        bus_if.port_id = 8'h00;
        @(negedge clk);
        check("cs", {31'h0, cs}, {31'h0, m_en});
        check("bit8", {31'h0, bit8}, {31'h0, m_b8});
        check("parity_en", {31'h0, parity_en}, {31'h0, m_pe});
        check("baud_prescale", {12'h0, baud_prescale}, {12'h0, m_pre});
        check("irq", {31'h0, irq}, {31'h0, m_irqen && (m_q.size() != 0 || m_ovr)});
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d); step(0, 1, a, d, 0, 11'h0); endtask
    task automatic rd(input logic [7:0] a);                      step(1, 0, a, 8'h0, 0, 11'h0); endtask
    task automatic rx(input logic [10:0] f);                     step(0, 0, 8'h0, 8'h0, 1, f); endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        @(posedge clk); #1;
        reset = 1;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        bus_if.port_id = 8'h00; bus_if.read_strobe = 0; bus_if.write_strobe = 0; bus_if.out_port = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_port", {24'h0, bus_if.in_port}, 32'h0);
        check("rst_cs", {31'h0, cs}, 32'h0);
        check("rst_prescale", {12'h0, baud_prescale}, 32'd325);
        check("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1;
        rd(A_ST);
        check("rst_status", {24'h0, last_rd}, 32'h01);

        // Prescale and control, then the lock while enabled
        wr(A_P0, 8'h45); wr(A_P1, 8'h01); wr(A_P2, 8'h00); wr(A_CTRL, 8'h17);
        check("cfg_prescale", {12'h0, baud_prescale}, 32'h00145);
        check("cfg_bits", {29'h0, cs, bit8, parity_en}, 32'h7);
        wr(A_P0, 8'hFF);
        check("locked_prescale", {12'h0, baud_prescale}, 32'h00145);

        // Parity and stop-bit errors, even parity, 9-bit mode
        rx({1'b1, 1'b0, 9'h0A5}); rd(A_ST); check("perr0", {24'h0, last_rd}, 32'h00);
        rd(A_DATA); check("data_a5", {24'h0, last_rd}, 32'hA5);
        rx({1'b1, 1'b1, 9'h0A5}); rd(A_ST); check("perr1", {24'h0, last_rd}, 32'h08);
        rd(A_DATA);
        rx({1'b0, 1'b0, 9'h0A5}); rd(A_ST); check("ferr1", {24'h0, last_rd}, 32'h10);
        rd(A_DATA); rd(A_ST); check("empty_again", {24'h0, last_rd}, 32'h01);

        // Overflow and draining
        for (int i = 1; i <= 5; i++) rx({2'b10, 9'(i)});
        rd(A_ST);
        check("full_ovr", {30'h0, last_rd[2:1]}, 32'h3);
        check("ovr_irq", {31'h0, irq}, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            rd(A_DATA); check("drain", {24'h0, last_rd}, i);
        end
        wr(A_ST, 8'h04);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // Push and pop coinciding on a full FIFO
        for (int i = 1; i <= 4; i++) rx({2'b10, 9'(8'h10 + 8'(i))});
        step(1, 0, A_DATA, 8'h0, 1, {2'b10, 9'h015});
        check("coinc_head", {24'h0, last_rd}, 32'h11);
        rd(A_ST); check("coinc_status", {29'h0, last_rd[2:0]}, 32'h2);
        for (int i = 2; i <= 5; i++) begin
            rd(A_DATA); check("coinc_order", {24'h0, last_rd}, 32'h10 + i);
        end

        // Disable coinciding with rx_done, then ignored frames, then reset
        step(0, 1, A_CTRL, 8'h00, 1, {2'b10, 9'h033});
        rx({2'b10, 9'h044});
        rd(A_ST); check("disable_capture", {24'h0, last_rd}, 32'h00);
        check("disabled_irq", {31'h0, irq}, 32'h0);
        wr(A_CTRL, 8'h01); rx({2'b10, 9'h055});
        do_reset();
        check("rst2_prescale", {12'h0, baud_prescale}, 32'd325);
        rd(A_ST); check("rst2_status", {24'h0, last_rd}, 32'h01);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int op;
            logic [7:0] a, d;
            logic [10:0] f;
            op = $urandom_range(0, 19);
            a  = BASE - 8'd1 + 8'($urandom_range(0, 7));
            d  = 8'($urandom);
            f  = 11'($urandom);
            if (op < 4) begin
                if ($urandom_range(0, 1) == 1) a = A_CTRL;
                wr(a, d);
            end else if (op < 9)  rd(a);
            else if (op < 14)     rx(f);
            else if (op < 17)     step(1, 0, A_DATA, 8'h0, 1, f);
            else if (op < 19) begin
                if (a == A_ST) a = A_CTRL;
                step(0, 1, a, d, 1, f);
            end else if ($urandom_range(0, 4) == 0) do_reset();
            else rd(A_ST);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
